// File: rtl/bg_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : bg_copy_engine
// Brief    : Copies one of NUM_BG full-screen images from external SRAM into
//            the on-chip frame buffer, or fills the frame buffer with a
//            constant word. Both sides use req/ack handshakes and a fixed
//            word count.
// Revision : 1.0 - initial release
// ============================================================================
module bg_copy_engine #(
  parameter int DATA_W    = 16,
  parameter int SRAM_AW   = 20,
  parameter int OCM_AW    = 19,
  parameter int NUM_BG    = 4,
  parameter int IMG_WORDS = 153600,
  parameter int SEL_W     = (NUM_BG > 1) ? $clog2(NUM_BG) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [SEL_W-1:0]   BG_Sel,
  input  logic               Mode,
  input  logic [DATA_W-1:0]  Fill_Data,
  output logic               SRAM_req,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  input  logic               SRAM_ack,
  input  logic [DATA_W-1:0]  SRAM_DATA,
  output logic               OCM_req,
  output logic [OCM_AW-1:0]  OCM_ADDR,
  output logic [DATA_W-1:0]  OCM_DATA,
  input  logic               OCM_ack,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam int IDX_W = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;

  localparam logic [IDX_W-1:0]   c_last_idx  = IDX_W'(IMG_WORDS - 1);
  localparam logic [SRAM_AW-1:0] c_img_words = SRAM_AW'(IMG_WORDS);
  localparam logic [OCM_AW-1:0]  c_bytes     = OCM_AW'(DATA_W / 8);
  localparam logic [31:0]        c_num_bg    = 32'(NUM_BG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_RD    = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic               r_mode;
  logic [DATA_W-1:0]  r_fill;
  logic [DATA_W-1:0]  r_data;
  logic [IDX_W-1:0]   r_idx;
  logic [SRAM_AW-1:0] r_base;
  logic               r_aborted;

  // Control FSM: operand capture, word sequencing and abort handling.
  // Abort in any active state wins over every handshake, including the
  // final OCM ack; in IDLE it only suppresses a coincident start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_mode    <= 1'b0;
      r_fill    <= '0;
      r_data    <= '0;
      r_idx     <= '0;
      r_base    <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= 1'b0;
      if ((r_state != S_IDLE) && abort) begin
        r_state   <= S_IDLE;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              r_state <= S_LATCH;
              // Selects beyond the stored image count fall back to image 0.
              r_sel   <= (32'(BG_Sel) >= c_num_bg) ? '0 : BG_Sel;
              r_mode  <= Mode;
              r_fill  <= Fill_Data;
              r_idx   <= '0;
            end
          end
          S_LATCH: begin
            // Multiply once per operation, truncated to the SRAM address space.
            r_base  <= SRAM_AW'(r_sel) * c_img_words;
            r_state <= r_mode ? S_WR : S_RD;
          end
          S_RD: begin
            if (SRAM_ack) begin
              r_data  <= SRAM_DATA;
              r_state <= S_WR;
            end
          end
          S_WR: begin
            if (OCM_ack) begin
              if (r_idx == c_last_idx) begin
                r_state <= S_DONE;
              end else begin
                r_idx   <= r_idx + IDX_W'(1);
                r_state <= r_mode ? S_WR : S_RD;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Outputs decode from the state register or combine registered operands
  // only, so no input reaches an output within the same cycle.
  assign busy      = (r_state != S_IDLE);
  assign SRAM_req  = (r_state == S_RD);
  assign OCM_req   = (r_state == S_WR);
  assign done      = (r_state == S_DONE);
  assign aborted   = r_aborted;
  assign SRAM_ADDR = r_base + SRAM_AW'(r_idx);
  assign OCM_ADDR  = OCM_AW'(r_idx) * c_bytes;
  assign OCM_DATA  = r_mode ? r_fill : r_data;

endmodule
`default_nettype wire

// File: tb/tb_bg_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_bg_copy_engine
// Brief    : Directed self-checking bench for bg_copy_engine with a small
//            configuration (8 words per image, 3 images, 16-bit words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bg_copy_engine;

  localparam int DATA_W    = 16;
  localparam int SRAM_AW   = 20;
  localparam int OCM_AW    = 19;
  localparam int NUM_BG    = 3;
  localparam int IMG_WORDS = 8;
  localparam int SEL_W     = 2;

  logic               Clk;
  logic               Reset_n;
  logic               start;
  logic               abort;
  logic [SEL_W-1:0]   BG_Sel;
  logic               Mode;
  logic [DATA_W-1:0]  Fill_Data;
  logic               SRAM_req;
  logic [SRAM_AW-1:0] SRAM_ADDR;
  logic               SRAM_ack;
  logic [DATA_W-1:0]  SRAM_DATA;
  logic               OCM_req;
  logic [OCM_AW-1:0]  OCM_ADDR;
  logic [DATA_W-1:0]  OCM_DATA;
  logic               OCM_ack;
  logic               busy;
  logic               done;
  logic               aborted;

  int n_checks = 0;
  int n_fail   = 0;

  bg_copy_engine #(
    .DATA_W(DATA_W), .SRAM_AW(SRAM_AW), .OCM_AW(OCM_AW),
    .NUM_BG(NUM_BG), .IMG_WORDS(IMG_WORDS), .SEL_W(SEL_W)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .abort(abort),
    .BG_Sel(BG_Sel), .Mode(Mode), .Fill_Data(Fill_Data),
    .SRAM_req(SRAM_req), .SRAM_ADDR(SRAM_ADDR), .SRAM_ack(SRAM_ack),
    .SRAM_DATA(SRAM_DATA), .OCM_req(OCM_req), .OCM_ADDR(OCM_ADDR),
    .OCM_DATA(OCM_DATA), .OCM_ack(OCM_ack), .busy(busy), .done(done),
    .aborted(aborted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM contents: a fixed address-dependent pattern.
  function automatic logic [15:0] sdata(input logic [19:0] a);
    return 16'hC300 ^ {a[7:0], ~a[7:0]};
  endfunction

  always_comb SRAM_DATA = sdata(SRAM_ADDR);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Zero-wait copy of one image; entered and left in IDLE, 1ns after an edge.
  task automatic copy_run(input logic [1:0] sel, input int base);
    int k;
    BG_Sel = sel; Mode = 1'b0; SRAM_ack = 1'b1; OCM_ack = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("copy latch busy", busy, 1);
    chk("copy latch sreq", SRAM_req, 0);
    for (int c = 2; c <= 18; c++) begin
      tick();
      chk($sformatf("copy c%0d done", c), done, (c == 18));
      chk($sformatf("copy c%0d busy", c), busy, 1);
      if (c < 18) begin
        k = (c - 2) / 2;
        if ((c % 2) == 0) begin
          chk($sformatf("copy c%0d sreq", c), SRAM_req, 1);
          chk($sformatf("copy c%0d saddr", c), SRAM_ADDR, base + k);
          chk($sformatf("copy c%0d oreq", c), OCM_req, 0);
        end else begin
          chk($sformatf("copy c%0d oreq", c), OCM_req, 1);
          chk($sformatf("copy c%0d oaddr", c), OCM_ADDR, 2 * k);
          chk($sformatf("copy c%0d odata", c), OCM_DATA, sdata(20'(base + k)));
        end
      end
    end
    tick();
    chk("copy end busy", busy, 0);
    chk("copy end done", done, 0);
  endtask

  initial begin
    int stall;
    Reset_n = 1'b0; start = 1'b0; abort = 1'b0; BG_Sel = '0; Mode = 1'b0;
    Fill_Data = '0; SRAM_ack = 1'b0; OCM_ack = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst sreq", SRAM_req, 0);
    chk("rst saddr", SRAM_ADDR, 0);
    chk("rst oreq", OCM_req, 0);
    chk("rst oaddr", OCM_ADDR, 0);
    chk("rst odata", OCM_DATA, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst aborted", aborted, 0);
    Reset_n = 1'b1;
    tick();

    // Copy image 2: SRAM 16..23
    copy_run(2'd2, 16);

    // Fill with random OCM stalls
    BG_Sel = 2'd0; Mode = 1'b1; Fill_Data = 16'hA5A5; SRAM_ack = 1'b0; OCM_ack = 1'b0;
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    for (int w = 0; w < 8; w++) begin
      stall = int'($urandom_range(0, 3));
      for (int s = 0; s <= stall; s++) begin
        chk($sformatf("fill w%0d s%0d oreq", w, s), OCM_req, 1);
        chk($sformatf("fill w%0d s%0d oaddr", w, s), OCM_ADDR, 2 * w);
        chk($sformatf("fill w%0d s%0d odata", w, s), OCM_DATA, 16'hA5A5);
        chk($sformatf("fill w%0d s%0d sreq", w, s), SRAM_req, 0);
        if (s == stall) OCM_ack = 1'b1;
        tick();
        OCM_ack = 1'b0;
      end
    end
    chk("fill done", done, 1);
    chk("fill done sreq", SRAM_req, 0);
    chk("fill done oreq", OCM_req, 0);
    tick();
    chk("fill end busy", busy, 0);
    chk("fill end done", done, 0);

    // Out-of-range select falls back to image 0
    copy_run(2'd3, 0);

    // Abort while the read of word 4 is stalled
    BG_Sel = 2'd1; Mode = 1'b0; SRAM_ack = 1'b1; OCM_ack = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    repeat (8) tick();
    chk("abort c9 oreq", OCM_req, 1);
    chk("abort c9 oaddr", OCM_ADDR, 6);
    SRAM_ack = 1'b0;
    tick();
    chk("abort c10 sreq", SRAM_req, 1);
    chk("abort c10 saddr", SRAM_ADDR, 12);
    tick();
    chk("abort c11 sreq", SRAM_req, 1);
    chk("abort c11 saddr", SRAM_ADDR, 12);
    abort = 1'b1;
    tick();
    chk("abort pulse", aborted, 1);
    chk("abort no done", done, 0);
    chk("abort sreq", SRAM_req, 0);
    chk("abort oreq", OCM_req, 0);
    abort = 1'b0; SRAM_ack = 1'b1; OCM_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post abort %0d aborted", i), aborted, 0);
      chk($sformatf("post abort %0d done", i), done, 0);
      chk($sformatf("post abort %0d oreq", i), OCM_req, 0);
      chk($sformatf("post abort %0d sreq", i), SRAM_req, 0);
      chk($sformatf("post abort %0d busy", i), busy, 0);
    end
    copy_run(2'd0, 0);

    // Start while busy is ignored; abort coincides with the final ack
    Mode = 1'b1; Fill_Data = 16'h0F0F; OCM_ack = 1'b1; SRAM_ack = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("sim c2 odata", OCM_DATA, 16'h0F0F);
    chk("sim c2 oaddr", OCM_ADDR, 0);
    tick();
    start = 1'b1; Mode = 1'b0; Fill_Data = 16'h1234; BG_Sel = 2'd1;
    tick();
    start = 1'b0;
    chk("busy start odata", OCM_DATA, 16'h0F0F);
    chk("busy start oreq", OCM_req, 1);
    chk("busy start oaddr", OCM_ADDR, 4);
    chk("busy start sreq", SRAM_req, 0);
    repeat (5) tick();
    chk("sim c9 oaddr", OCM_ADDR, 14);
    chk("sim c9 oreq", OCM_req, 1);
    abort = 1'b1;
    tick();
    chk("sim aborted", aborted, 1);
    chk("sim done", done, 0);
    abort = 1'b0;
    tick();
    chk("sim after done", done, 0);
    chk("sim after aborted", aborted, 0);
    chk("sim after busy", busy, 0);

    // Asynchronous reset in the middle of a fill
    Mode = 1'b1; Fill_Data = 16'h3C3C; OCM_ack = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    chk("arst pre oreq", OCM_req, 1);
    chk("arst pre odata", OCM_DATA, 16'h3C3C);
    #3 Reset_n = 1'b0;
    #1;
    chk("arst oreq", OCM_req, 0);
    chk("arst oaddr", OCM_ADDR, 0);
    chk("arst odata", OCM_DATA, 0);
    chk("arst sreq", SRAM_req, 0);
    chk("arst saddr", SRAM_ADDR, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst aborted", aborted, 0);
    tick();
    chk("arst hold busy", busy, 0);
    chk("arst hold aborted", aborted, 0);
    Reset_n = 1'b1;
    tick();
    chk("arst rel busy", busy, 0);
    chk("arst rel done", done, 0);
    chk("arst rel aborted", aborted, 0);
    chk("arst rel oreq", OCM_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
